// File: rtl/multicycle_control_fsm_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm_pkg
//
// Shared types for the multicycle RV32I control path:
//   opcode_t     - RV32I major opcodes as held in IR[6:0]
//   alu_op_t     - ALU operation class handed to ALUdecoder
//   ctrl_state_t - 4-bit sequencer state encoding
//   ctrl_word_t  - one cycle's worth of datapath control signals
// Plus the encodings of the ALU A/B and result multiplexer selects.
//
// Optional build macro: ILLEGAL_INSTR_TRAP_EN adds the S_TRAP state.
// ---------------------------------------------------------------------------
package multicycle_control_fsm_pkg;

    typedef enum logic [6:0] {
        RType       = 7'b0110011,
        IType_load  = 7'b0000011,
        IType_logic = 7'b0010011,
        IType_jalr  = 7'b1100111,
        SType       = 7'b0100011,
        BType       = 7'b1100011,
        JType       = 7'b1101111,
        UType_lui   = 7'b0110111,
        UType_auipc = 7'b0010111,
        FENCE       = 7'b0001111
    } opcode_t;

    typedef enum logic [1:0] {
        ALU_OP__ADD                = 2'd0,
        ALU_OP__REGISTER_OPERATION = 2'd1,
        ALU_OP__BRANCH             = 2'd2,
        ALU_OP__UNSET              = 2'd3
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
`ifdef ILLEGAL_INSTR_TRAP_EN
        , S_TRAP   = 4'd13
`endif
    } ctrl_state_t;

    // ALU operand A select
    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_A_RS1   = 2'b10;
    localparam logic [1:0] ALU_A_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] ALU_B_RS2   = 2'b00;
    localparam logic [1:0] ALU_B_IMM   = 2'b01;
    localparam logic [1:0] ALU_B_FOUR  = 2'b10;

    // Result bus select
    localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
    localparam logic [1:0] RESULT_MEMDATA = 2'b01;
    localparam logic [1:0] RESULT_ALU     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        alu_op_t    alu_op;
    } ctrl_word_t;

    // Control word with every strobe and select at 0 and no ALU operation.
    function automatic ctrl_word_t ctrl_idle();
        ctrl_word_t w;
        w        = '0;
        w.alu_op = ALU_OP__UNSET;
        return w;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_output_decode.sv
// ---------------------------------------------------------------------------
// ctrl_output_decode
//
// Pure state -> control word map for the multicycle sequencer. Moore decode,
// except that ir_write / pc_update in FETCH follow mem_ready so the fetched
// word and PC+4 are captured in the very cycle memory completes.
//
// Ports:
//   state     in  current sequencer state
//   mem_ready in  memory completes the current request this cycle
//   ctrl      out datapath control word for this cycle
//
// Optional build macro: ILLEGAL_INSTR_TRAP_EN (S_TRAP decodes to idle).
// ---------------------------------------------------------------------------
module ctrl_output_decode
    import multicycle_control_fsm_pkg::*;
(
    input  ctrl_state_t state,
    input  logic        mem_ready,
    output ctrl_word_t  ctrl
);

    always_comb begin
        ctrl = ctrl_idle();
        case (state)
            S_FETCH: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b0;
                ctrl.alu_src_a  = ALU_A_PC;
                ctrl.alu_src_b  = ALU_B_FOUR;
                ctrl.alu_op     = ALU_OP__ADD;
                ctrl.result_src = RESULT_ALU;
                ctrl.ir_write   = mem_ready;
                ctrl.pc_update  = mem_ready;
            end
            S_DECODE: begin
                // ALUOut <= oldPC + imm, the branch/JAL target.
                ctrl.alu_src_a = ALU_A_OLDPC;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP__ADD;
            end
            S_MEMADR, S_JALR: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP__ADD;
            end
            S_MEMREAD: begin
                ctrl.mem_req    = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RESULT_ALUOUT;
            end
            S_MEMWB: begin
                ctrl.result_src = RESULT_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl.mem_req    = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.adr_src    = 1'b1;
                ctrl.result_src = RESULT_ALUOUT;
            end
            S_EXECUTER: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_RS2;
                ctrl.alu_op    = ALU_OP__REGISTER_OPERATION;
            end
            S_EXECUTEI: begin
                ctrl.alu_src_a = ALU_A_RS1;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP__REGISTER_OPERATION;
            end
            S_ALUWB: begin
                ctrl.result_src = RESULT_ALUOUT;
                ctrl.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = ALU_A_RS1;
                ctrl.alu_src_b  = ALU_B_RS2;
                ctrl.alu_op     = ALU_OP__BRANCH;
                ctrl.result_src = RESULT_ALUOUT;
                ctrl.branch     = 1'b1;
            end
            S_JAL: begin
                // PC <= ALUOut (target) while the ALU forms oldPC + 4,
                // which ALUWB then writes to rd as the link value.
                ctrl.alu_src_a  = ALU_A_OLDPC;
                ctrl.alu_src_b  = ALU_B_FOUR;
                ctrl.alu_op     = ALU_OP__ADD;
                ctrl.result_src = RESULT_ALUOUT;
                ctrl.pc_update  = 1'b1;
            end
            S_LUI: begin
                ctrl.alu_src_a = ALU_A_ZERO;
                ctrl.alu_src_b = ALU_B_IMM;
                ctrl.alu_op    = ALU_OP__ADD;
            end
            default: ctrl = ctrl_idle();
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main sequencer of the multicycle RV32I core. Steps the shared datapath
// through fetch / decode / execute / memory / write-back and owns every
// datapath write strobe plus the memory request.
//
// Memory handshake: mem_req is the request valid and mem_ready the
// completion; a request (with adr_src and mem_write) is held unchanged until
// the cycle mem_ready is 1, and mem_ready is ignored while mem_req is 0.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   opcode                  opcode of the instruction in IR
//   mem_ready               memory completes the current request
//   mem_req, mem_write      memory request valid / request is a store
//   adr_src                 memory address select (0 PC, 1 result)
//   ir_write, pc_update     IR/oldPC latch, unconditional PC write
//   branch, reg_write       conditional PC write, register-file write
//   alu_src_a/b, result_src datapath multiplexer selects
//   alu_op                  ALU operation class for ALUdecoder
//   state_o                 current state, for debug
//   illegal_instr           trap indicator (ILLEGAL_INSTR_TRAP_EN only)
//
// Optional build macro: ILLEGAL_INSTR_TRAP_EN - unrecognised opcodes enter a
// sticky S_TRAP state instead of retiring as no-ops.
// ---------------------------------------------------------------------------
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  opcode_t     opcode,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_update,
    output logic        branch,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output alu_op_t     alu_op,
    output ctrl_state_t state_o
`ifdef ILLEGAL_INSTR_TRAP_EN
    ,
    output logic        illegal_instr
`endif
);

    ctrl_state_t state, next_state;
    ctrl_word_t  ctrl_raw, ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    IType_load, SType: next_state = S_MEMADR;
                    RType:             next_state = S_EXECUTER;
                    IType_logic:       next_state = S_EXECUTEI;
                    BType:             next_state = S_BRANCH;
                    JType:             next_state = S_JAL;
                    IType_jalr:        next_state = S_JALR;
                    UType_lui:         next_state = S_LUI;
                    UType_auipc:       next_state = S_ALUWB; // DECODE formed oldPC+imm
                    FENCE:             next_state = S_FETCH;
`ifdef ILLEGAL_INSTR_TRAP_EN
                    default:           next_state = S_TRAP;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            // IR still holds the instruction, so it tells load from store.
            S_MEMADR:   next_state = (opcode == SType) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECUTER: next_state = S_ALUWB;
            S_EXECUTEI: next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_JALR:     next_state = S_JAL;
            S_LUI:      next_state = S_ALUWB;
`ifdef ILLEGAL_INSTR_TRAP_EN
            S_TRAP:     next_state = S_TRAP;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    ctrl_output_decode u_output_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Gating with reset_n makes every strobe and any in-flight request drop
    // the moment reset asserts, without waiting for a clock edge.
    always_comb begin
        ctrl = ctrl_raw;
        if (!reset_n) ctrl = ctrl_idle();
    end

    assign mem_req    = ctrl.mem_req;
    assign mem_write  = ctrl.mem_write;
    assign adr_src    = ctrl.adr_src;
    assign ir_write   = ctrl.ir_write;
    assign pc_update  = ctrl.pc_update;
    assign branch     = ctrl.branch;
    assign reg_write  = ctrl.reg_write;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign result_src = ctrl.result_src;
    assign alu_op     = ctrl.alu_op;
    assign state_o    = state;

`ifdef ILLEGAL_INSTR_TRAP_EN
    assign illegal_instr = reset_n && (state == S_TRAP);
`endif

endmodule
